seq_multiplier_radix: RTL and testbench

- Parametrised, constant-latency, sequential shift-add multiplier. Next generation of the team's constant-time multiplier.
- Adds:
  - configurable operand width and digit size (radix 2^BITS_PER_CYCLE);
  - a per-operation signed/unsigned mode;
  - explicit busy/done status.
- Sits as a shared arithmetic unit behind a controller that issues one start pulse per operation.
- Latency is independent of operand values, so timing does not leak data.

---
 rtl/seq_multiplier_radix.sv | 130 +++++++++++++
 tb/tb_seq_multiplier_radix.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_radix.sv
// Constant-latency radix-2^BITS_PER_CYCLE shift-add multiplier.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
module seq_multiplier_radix #(
  parameter int NUM_BITS       = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic [NUM_BITS-1:0]     multiplier,
  input  logic [NUM_BITS-1:0]     multiplicand,
  output logic                    busy,
  output logic                    done,
  output logic [2*NUM_BITS-1:0]   product
);

  localparam int STEPS = (BITS_PER_CYCLE > 0)
                       ? NUM_BITS / BITS_PER_CYCLE : 1;
  localparam int PW    = 2 * NUM_BITS;
  localparam int AW    = PW + 1;
  localparam int CW    = $clog2(STEPS + 1);

  generate
    if (NUM_BITS < 2 || BITS_PER_CYCLE < 1 ||
        (NUM_BITS % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("seq_multiplier_radix: illegal NUM_BITS/BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CW-1:0]             r_cnt;
  logic                      r_sign;
  logic [NUM_BITS-1:0]       r_mag_a;
  logic [PW-1:0]             r_mag_b_sh;
  logic [AW-1:0]             r_acc;
  logic [PW-1:0]             r_prod;
  logic                      r_done;

  logic [NUM_BITS-1:0]       w_neg_a;
  logic [NUM_BITS-1:0]       w_neg_b;
  logic [NUM_BITS-1:0]       w_mag_a;
  logic [NUM_BITS-1:0]       w_mag_b;
  logic                      w_sign;
  logic [BITS_PER_CYCLE-1:0] w_digit;
  logic [AW-1:0]             w_pp;
  logic [PW-1:0]             w_acc_lo;
  logic [PW-1:0]             w_res;
  logic                      w_unused;

  assign w_neg_a = NUM_BITS'(0) - multiplier;
  assign w_neg_b = NUM_BITS'(0) - multiplicand;
  assign w_mag_a = (signed_mode && multiplier[NUM_BITS-1])
                 ? w_neg_a : multiplier;
  assign w_mag_b = (signed_mode && multiplicand[NUM_BITS-1])
                 ? w_neg_b : multiplicand;
  assign w_sign  = signed_mode &
                   (multiplier[NUM_BITS-1] ^ multiplicand[NUM_BITS-1]);

  // The multiplicand is pre-shifted each step, so the partial
  // product already carries its k*BITS_PER_CYCLE weight.
  assign w_digit  = r_mag_a[BITS_PER_CYCLE-1:0];
  assign w_pp     = AW'(r_mag_b_sh) * AW'(w_digit);
  assign w_acc_lo = r_acc[PW-1:0];
  assign w_res    = r_sign ? (PW'(0) - w_acc_lo) : w_acc_lo;
  assign w_unused = r_acc[AW-1];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_mag_a    <= '0;
      r_mag_b_sh <= '0;
      r_acc      <= '0;
      r_prod     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign     <= w_sign;
            r_mag_a    <= w_mag_a;
            r_mag_b_sh <= PW'(w_mag_b);
            r_acc      <= '0;
            r_cnt      <= CW'(STEPS);
          end
        end
        S_CALC: begin
          r_acc      <= r_acc + w_pp;
          r_mag_a    <= r_mag_a >> BITS_PER_CYCLE;
          r_mag_b_sh <= r_mag_b_sh << BITS_PER_CYCLE;
          r_cnt      <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_prod <= w_res;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign product = r_prod;

endmodule

// File: tb/tb_seq_multiplier_radix.sv
// Bench for seq_multiplier_radix: radix-2 and radix-4 instances
// share stimulus; results come from vector tables and a reference model.
module tb_seq_multiplier_radix;

  localparam int N  = 8;
  localparam int L1 = 9;
  localparam int L2 = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         smode = 1'b0;
  logic [N-1:0] ma = '0;
  logic [N-1:0] mb = '0;
  logic         busy1, done1, busy2, done2;
  logic [2*N-1:0] prod1, prod2;

  int checks = 0;
  int failures = 0;
  logic [2*N-1:0] prev1 = '0;
  logic [2*N-1:0] prev2 = '0;

  always #5 clk = ~clk;

  seq_multiplier_radix #(.NUM_BITS(N), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(smode),
    .multiplier(ma), .multiplicand(mb),
    .busy(busy1), .done(done1), .product(prod1)
  );

  seq_multiplier_radix #(.NUM_BITS(N), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(smode),
    .multiplier(ma), .multiplicand(mb),
    .busy(busy2), .done(done2), .product(prod2)
  );

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           s;
    logic [2*N-1:0] exp;
  } vec_t;

  function automatic logic [2*N-1:0] ref_mul(
    input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    longint p;
    logic [63:0] pv;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'({1'b0, a}) * longint'({1'b0, b});
    pv = p;
    return pv[2*N-1:0];
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic launch(input logic [N-1:0] a,
                        input logic [N-1:0] b,
                        input logic s);
    @(negedge clk);
    ma = a; mb = b; smode = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Walks edges E0+1..E0+10 checking both instances.
  // inj: edge after which a stray start is raised for one edge.
  // chain: at E0+9 raise start with (ca,cb) and return.
  task automatic track(input logic [2*N-1:0] x,
                       input int inj, input bit chain,
                       input logic [N-1:0] ca,
                       input logic [N-1:0] cb);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      chk("done1", 32'(done1), 32'(e == L1));
      chk("busy1", 32'(busy1), 32'(e < L1));
      chk("prod1", 32'(prod1), 32'((e >= L1) ? x : prev1));
      chk("done2", 32'(done2), 32'(e == L2));
      chk("busy2", 32'(busy2), 32'(e < L2));
      chk("prod2", 32'(prod2), 32'((e >= L2) ? x : prev2));
      if (inj != 0 && e == inj) begin
        ma = 8'd3; mb = 8'd3; start = 1'b1;
      end
      if (inj != 0 && e == inj + 1) start = 1'b0;
      if (chain && e == L1) begin
        ma = ca; mb = cb; smode = 1'b0; start = 1'b1;
        break;
      end
    end
    prev1 = x;
    prev2 = x;
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back('{8'd15,  8'd15,  1'b0, 16'd225});
    vt.push_back('{8'd92,  8'd75,  1'b0, 16'd6900});
    vt.push_back('{8'd0,   8'd12,  1'b0, 16'd0});
    vt.push_back('{8'hFD,  8'h05,  1'b1, 16'hFFF1});
    vt.push_back('{8'h80,  8'h80,  1'b1, 16'h4000});
    vt.push_back('{8'h80,  8'h7F,  1'b1, 16'hC080});
    vt.push_back('{8'hFD,  8'h05,  1'b0, 16'd1265});
    vt.push_back('{8'hFF,  8'hFF,  1'b0, 16'hFE01});
    vt.push_back('{8'hFF,  8'h01,  1'b1, 16'hFFFF});

    // Reset state
    #12;
    chk("rst_busy", 32'({busy1, busy2}), 32'd0);
    chk("rst_done", 32'({done1, done2}), 32'd0);
    chk("rst_prod1", 32'(prod1), 32'd0);
    chk("rst_prod2", 32'(prod2), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vt[i]) begin
      launch(vt[i].a, vt[i].b, vt[i].s);
      track(vt[i].exp, 0, 1'b0, '0, '0);
    end

    // start while busy is ignored
    launch(8'd15, 8'd15, 1'b0);
    track(16'd225, 3, 1'b0, '0, '0);

    // start held in the done cycle: accepted at E0+10
    launch(8'd15, 8'd15, 1'b0);
    track(16'd225, 0, 1'b1, 8'd1, 8'd2);
    @(posedge clk);
    #1 start = 1'b0;
    track(16'd2, 0, 1'b0, '0, '0);

    // asynchronous reset mid-operation
    launch(8'd15, 8'd15, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", 32'({busy1, busy2}), 32'd0);
    chk("arst_done", 32'({done1, done2}), 32'd0);
    chk("arst_prod", 32'({prod1, prod2}), 32'd0);
    prev1 = '0;
    prev2 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk("no_done_after_rst", 32'({done1, done2, busy1, busy2}), 32'd0);
    end
    launch(8'd7, 8'd6, 1'b0);
    track(16'd42, 0, 1'b0, '0, '0);

    // randomized operands against the reference model
    for (int r = 0; r < 24; r++) begin
      logic [N-1:0] a, b;
      logic s;
      a = N'($urandom);
      b = N'($urandom);
      s = 1'($urandom);
      launch(a, b, s);
      track(ref_mul(a, b, s), 0, 1'b0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
